bit_destuffer: RTL and testbench

BIT_DESTUFFER -- requirements
Module: bit_destuffer

---
 rtl/can_pkg.sv | 19 +
 rtl/bit_destuffer.sv | 122 ++++++++++++
 tb/tb_bit_destuffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN bit destuffer.
package can_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RUN_W  = 3;
    localparam int unsigned CNT_W  = 3;

    localparam logic [RUN_W-1:0] STUFF_LIMIT = 3'd5;
    localparam logic [RUN_W-1:0] RUN_ONE     = 3'd1;
    localparam logic [RUN_W-1:0] RUN_ZERO    = 3'd0;
    localparam logic [CNT_W-1:0] CNT_LAST    = 3'd7;
    localparam logic [CNT_W-1:0] CNT_ZERO    = 3'd0;

    typedef enum logic {
        IDLE       = 1'b0,
        STUFF_AREA = 1'b1
    } state_t;

endpackage

// File: rtl/bit_destuffer.sv
// Removes CAN stuff bits inside the stuffing region and assembles destuffed
// bits into bytes; all outputs are registered one cycle after the sample point.
module bit_destuffer
    import can_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              SP,
    input  logic              RX,
    input  logic              F_STF,
    output logic              BIT_OUT,
    output logic              BIT_VALID,
    output logic              STUFF_DROP,
    output logic              STUFF_VIOL,
    output logic [BYTE_W-1:0] SHIFT,
    output logic              BYTE_RDY
);

    state_t              state_r, state_s;
    logic [RUN_W-1:0]    run_r, run_s;
    logic                prev_r, prev_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s, cnt_base_s;
    logic [BYTE_W-1:0]   shift_s;
    logic                bit_out_s, valid_s, drop_s, viol_s, byte_s;
    logic                data_s, enter_s;

    // Next-state and output decode; everything holds unless SP marks a bit.
    always_comb begin
        state_s    = state_r;
        run_s      = run_r;
        prev_s     = prev_r;
        cnt_s      = cnt_r;
        cnt_base_s = cnt_r;
        shift_s    = SHIFT;
        bit_out_s  = BIT_OUT;
        valid_s    = 1'b0;
        drop_s     = 1'b0;
        viol_s     = 1'b0;
        byte_s     = 1'b0;
        data_s     = 1'b0;
        enter_s    = 1'b0;

        if (SP) begin
            case (state_r)
                IDLE: begin
                    data_s = 1'b1;
                    if (!F_STF) begin
                        state_s = STUFF_AREA;
                        enter_s = 1'b1;
                        prev_s  = RX;
                        run_s   = RUN_ONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                STUFF_AREA: begin
                    if (F_STF) begin
                        state_s = IDLE;
                        run_s   = RUN_ZERO;
                        data_s  = 1'b1;
                    end else if (run_r >= STUFF_LIMIT) begin
                        // Sixth bit after five equal bits is the stuff bit.
                        drop_s = 1'b1;
                        viol_s = (RX == prev_r);
                        prev_s = RX;
                        run_s  = RUN_ONE;
                    end else begin
                        data_s = 1'b1;
                        prev_s = RX;
                        run_s  = (RX == prev_r) ? run_r + RUN_ONE : RUN_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    run_s   = RUN_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // Byte framing restarts at region entry, before the entry bit is counted.
        if (data_s) begin
            cnt_base_s = enter_s ? CNT_ZERO : cnt_r;
            cnt_s      = cnt_base_s + 3'd1;
            byte_s     = (cnt_base_s == CNT_LAST);
            shift_s    = {SHIFT[BYTE_W-2:0], RX};
            bit_out_s  = RX;
            valid_s    = 1'b1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, run counter, shift register and output pulse registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            run_r      <= RUN_ZERO;
            prev_r     <= 1'b1;
            cnt_r      <= CNT_ZERO;
            SHIFT      <= 8'h00;
            BIT_OUT    <= 1'b1;
            BIT_VALID  <= 1'b0;
            STUFF_DROP <= 1'b0;
            STUFF_VIOL <= 1'b0;
            BYTE_RDY   <= 1'b0;
        end else begin
            state_r    <= state_s;
            run_r      <= run_s;
            prev_r     <= prev_s;
            cnt_r      <= cnt_s;
            SHIFT      <= shift_s;
            BIT_OUT    <= bit_out_s;
            BIT_VALID  <= valid_s;
            STUFF_DROP <= drop_s;
            STUFF_VIOL <= viol_s;
            BYTE_RDY   <= byte_s;
        end
    end

endmodule

// File: tb/tb_bit_destuffer.sv
// Self-checking bench for bit_destuffer: behavioural model with per-cycle
// comparison, directed scenarios with literal expectations, random traffic.
module tb_bit_destuffer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       SP = 1'b0;
    logic       RX = 1'b1;
    logic       F_STF = 1'b1;
    logic       BIT_OUT, BIT_VALID, STUFF_DROP, STUFF_VIOL, BYTE_RDY;
    logic [7:0] SHIFT;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    bit_destuffer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .SP         (SP),
        .RX         (RX),
        .F_STF      (F_STF),
        .BIT_OUT    (BIT_OUT),
        .BIT_VALID  (BIT_VALID),
        .STUFF_DROP (STUFF_DROP),
        .STUFF_VIOL (STUFF_VIOL),
        .SHIFT      (SHIFT),
        .BYTE_RDY   (BYTE_RDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected outputs after each rising edge.
    bit       m_region = 1'b0;
    int       m_run = 0;
    logic     m_prev = 1'b1;
    int       m_bits = 0;
    logic [7:0] e_shift = 8'h00;
    logic     e_out = 1'b1, e_valid = 1'b0, e_drop = 1'b0, e_viol = 1'b0, e_byte = 1'b0;

    always @(posedge clock) begin
        bit is_data;
        if (!reset_n) begin
            m_region = 1'b0; m_run = 0; m_prev = 1'b1; m_bits = 0;
            e_shift = 8'h00; e_out = 1'b1;
            e_valid = 1'b0; e_drop = 1'b0; e_viol = 1'b0; e_byte = 1'b0;
        end else begin
            e_valid = 1'b0; e_drop = 1'b0; e_viol = 1'b0; e_byte = 1'b0;
            if (SP) begin
                is_data = 1'b1;
                if (!m_region) begin
                    if (!F_STF) begin
                        m_region = 1'b1; m_run = 1; m_prev = RX; m_bits = 0;
                    end
                end else if (F_STF) begin
                    m_region = 1'b0; m_run = 0;
                end else if (m_run == 5) begin
                    is_data = 1'b0;
                    e_drop = 1'b1;
                    e_viol = (RX == m_prev);
                    m_prev = RX; m_run = 1;
                end else begin
                    m_run = (RX == m_prev) ? m_run + 1 : 1;
                    m_prev = RX;
                end
                if (is_data) begin
                    e_valid = 1'b1;
                    e_out = RX;
                    e_shift = {e_shift[6:0], RX};
                    m_bits = m_bits + 1;
                    if (m_bits == 8) begin
                        m_bits = 0;
                        e_byte = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of DUT against the model.
    always @(negedge clock) begin
        if (check_en) begin
            chk("bit_valid", {7'd0, BIT_VALID}, {7'd0, e_valid});
            chk("stuff_drop", {7'd0, STUFF_DROP}, {7'd0, e_drop});
            chk("stuff_viol", {7'd0, STUFF_VIOL}, {7'd0, e_viol});
            chk("byte_rdy", {7'd0, BYTE_RDY}, {7'd0, e_byte});
            chk("bit_out", {7'd0, BIT_OUT}, {7'd0, e_out});
            chk("shift", SHIFT, e_shift);
        end
    end

    logic       c_valid, c_drop, c_viol, c_byte, c_out;
    logic [7:0] c_shift;

    task automatic do_reset();
        @(negedge clock); reset_n = 1'b0; SP = 1'b0;
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic sp(input logic rx, input logic fstf, input int gap);
        @(negedge clock); SP = 1'b1; RX = rx; F_STF = fstf;
        @(negedge clock); SP = 1'b0;
        c_valid = BIT_VALID; c_drop = STUFF_DROP; c_viol = STUFF_VIOL;
        c_byte = BYTE_RDY; c_out = BIT_OUT; c_shift = SHIFT;
        repeat (gap) @(negedge clock);
    endtask

    initial begin
        int nv, nd, nb;
        logic [7:0] pat;
        pat = 8'b10110010;

        @(negedge clock); reset_n = 1'b0;
        @(negedge clock);
        check_en = 1'b1;
        chk("reset_bit_out", {7'd0, BIT_OUT}, 8'd1);
        chk("reset_shift", SHIFT, 8'h00);
        chk("reset_valid", {7'd0, BIT_VALID}, 8'd0);
        reset_n = 1'b1;

        // Five zeros, stuff one, then data zero.
        for (int i = 0; i < 5; i++) begin
            sp(1'b0, 1'b0, 0);
            chk("z5_valid", {7'd0, c_valid}, 8'd1);
            chk("z5_out", {7'd0, c_out}, 8'd0);
        end
        sp(1'b1, 1'b0, 0);
        chk("z5_drop", {7'd0, c_drop}, 8'd1);
        chk("z5_drop_valid", {7'd0, c_valid}, 8'd0);
        chk("z5_drop_viol", {7'd0, c_viol}, 8'd0);
        sp(1'b0, 1'b0, 0);
        chk("z5_after_valid", {7'd0, c_valid}, 8'd1);
        chk("z5_after_out", {7'd0, c_out}, 8'd0);

        // Six ones: violation; next one starts run at 2.
        do_reset();
        for (int i = 0; i < 5; i++) sp(1'b1, 1'b0, 0);
        sp(1'b1, 1'b0, 0);
        chk("o6_drop", {7'd0, c_drop}, 8'd1);
        chk("o6_viol", {7'd0, c_viol}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            sp(1'b1, 1'b0, 0);
            chk("o6_run_data", {7'd0, c_valid}, 8'd1);
        end
        sp(1'b1, 1'b0, 0);
        chk("o6_run2_drop", {7'd0, c_drop}, 8'd1);

        // One byte 0xB2 in the stuffed region.
        do_reset();
        nb = 0;
        for (int i = 7; i >= 0; i--) begin
            sp(pat[i], 1'b0, 0);
            nb += int'(c_byte);
        end
        chk("byte_count", nb[7:0], 8'd1);
        chk("byte_last", {7'd0, c_byte}, 8'd1);
        chk("byte_shift", c_shift, 8'hB2);

        // Unstuffed field: seven ones all pass.
        do_reset();
        nv = 0; nd = 0;
        for (int i = 0; i < 7; i++) begin
            sp(1'b1, 1'b1, 0);
            nv += int'(c_valid); nd += int'(c_drop);
        end
        chk("idle_valid_cnt", nv[7:0], 8'd7);
        chk("idle_drop_cnt", nd[7:0], 8'd0);

        // Reset collides with fifth SP.
        do_reset();
        for (int i = 0; i < 4; i++) sp(1'b0, 1'b0, 0);
        @(negedge clock); SP = 1'b1; RX = 1'b0; F_STF = 1'b0; reset_n = 1'b0;
        @(negedge clock); SP = 1'b0; reset_n = 1'b1;
        chk("rst_coll_valid", {7'd0, BIT_VALID}, 8'd0);
        chk("rst_coll_out", {7'd0, BIT_OUT}, 8'd1);
        chk("rst_coll_shift", SHIFT, 8'h00);
        @(negedge clock);
        chk("rst_post_valid", {7'd0, BIT_VALID}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            sp(1'b0, 1'b0, 0);
            chk("rst_run_data", {7'd0, c_valid}, 8'd1);
        end
        sp(1'b0, 1'b0, 0);
        chk("rst_run_drop", {7'd0, c_drop}, 8'd1);

        // Region entry with spaced SPs restarts byte framing.
        do_reset();
        for (int i = 0; i < 3; i++) sp(1'b1, 1'b1, 3);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            sp(i[0] ? 1'b0 : 1'b1, 1'b0, 3);
            if (i == 4) chk("entry_no_byte5", {7'd0, c_byte}, 8'd0);
            nb += int'(c_byte);
        end
        chk("entry_byte8", {7'd0, c_byte}, 8'd1);
        chk("entry_byte_cnt", nb[7:0], 8'd1);
        chk("entry_shift", c_shift, 8'hAA);
        sp(1'b1, 1'b1, 3);
        chk("exit_valid", {7'd0, c_valid}, 8'd1);

        // Random traffic, including SP held high and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            SP = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) RX = ~RX;
            if ($urandom_range(0, 24) == 0) F_STF = ~F_STF;
            reset_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clock); SP = 1'b0; reset_n = 1'b1;
        @(negedge clock);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
